// File: rtl/i2s_tx_fifo_if.sv
// ---------------------------------------------------------------------------
// i2s_tx_fifo_if
// Sample-word write channel into the I2S transmitter FIFO.
//   in_valid : producer has a stereo word on in_data this cycle
//   in_ready : FIFO can accept a word (a write happens on valid && ready)
//   in_data  : {left[2*SAMPLE_W-1:SAMPLE_W], right[SAMPLE_W-1:0]}
// The master modport is the bus-side producer; the slave modport is the
// transmitter.
// ---------------------------------------------------------------------------
interface i2s_tx_fifo_if #(
  parameter int SAMPLE_W = 16
);
  logic                  in_valid;
  logic                  in_ready;
  logic [2*SAMPLE_W-1:0] in_data;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/i2s_tx_fifo.sv
// ---------------------------------------------------------------------------
// i2s_tx_fifo
// Single-clock stereo I2S / left-justified serial transmitter with an input
// FIFO. bck and lrck are derived from clk by counting; one stereo word is
// popped at every frame start and serialised MSB first.
//
// Ports
//   clk          : system clock, all logic on the rising edge
//   reset        : synchronous, active-high
//   in_if        : write channel (in_valid / in_ready / in_data), slave side
//   enable       : run the serial output (sampled at frame boundaries)
//   justify      : 0 = I2S (one bck MSB delay), 1 = left-justified
//   audio_req    : one-clk request pulse when the FIFO runs low
//   level        : FIFO occupancy
//   underrun     : sticky flag, set when a frame starts with an empty FIFO
//   underrun_clr : clears underrun (a new underrun in the same cycle wins)
//   bck          : bit clock, 50% duty
//   lrck         : 0 = left slot, 1 = right slot
//   sout         : serial data
//
// Optional feature
//   I2S_TX_REPEAT_ON_UNDERRUN_EN : when defined, an underrun frame repeats the
//   last word popped from the FIFO (zeros if none since reset) instead of
//   transmitting zeros.
// ---------------------------------------------------------------------------
module i2s_tx_fifo #(
  parameter int SAMPLE_W   = 16,
  parameter int SLOT_W     = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int BCK_DIV    = 8,
  parameter int REQ_LEVEL  = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  i2s_tx_fifo_if.slave                    in_if,
  input  logic                            enable,
  input  logic                            justify,
  output logic                            audio_req,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] level,
  output logic                            underrun,
  input  logic                            underrun_clr,
  output logic                            bck,
  output logic                            lrck,
  output logic                            sout
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(FIFO_DEPTH + 1);
  localparam int DW = $clog2(BCK_DIV);
  localparam int BW = $clog2(2 * SLOT_W);
  localparam int WW = 2 * SAMPLE_W;

  localparam logic [DW-1:0] DIV_LAST = DW'(BCK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(BCK_DIV / 2);
  localparam logic [BW-1:0] BIT_LAST = BW'(2 * SLOT_W - 1);
  localparam logic [BW-1:0] SLOT_L   = BW'(SLOT_W);
  localparam logic [LW-1:0] DEPTH_L  = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0] REQ_L    = LW'(REQ_LEVEL);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [DW-1:0]   div_q, div_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic [WW-1:0]   word_q, word_d;
  logic            just_q, just_d;
  logic [WW-1:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   count_q, count_d;
  logic            in_ready_q, in_ready_d;
  logic            underrun_q, underrun_d;
  logic            audio_req_q, audio_req_d;
  logic            bck_q, bck_d;
  logic            lrck_q, lrck_d;
  logic            sout_q, sout_d;
`ifdef I2S_TX_REPEAT_ON_UNDERRUN_EN
  logic [WW-1:0]   last_q, last_d;
`endif

  logic            frame_start_s;
  logic            entering_s;
  logic            push_s;
  logic            pop_s;
  logic            empty_s;
  logic            div_wrap_s;
  logic            bit_last_s;
  logic [WW-1:0]   fill_word_s;

  // Serial bit for position b of the frame: slot position selects the sample
  // bit, left slot uses the upper half of the word, right slot the lower half.
  function automatic logic slot_bit(input logic [WW-1:0] w,
                                    input logic [BW-1:0] b,
                                    input logic          lj);
    logic [SAMPLE_W-1:0] smp;
    logic [SAMPLE_W-1:0] sh;
    logic [BW-1:0]       pos;
    logic                r;
    if (b >= SLOT_L) begin
      smp = w[SAMPLE_W-1:0];
      pos = b - SLOT_L;
    end else begin
      smp = w[WW-1:SAMPLE_W];
      pos = b;
    end
    sh = '0;
    r  = 1'b0;
    if (lj) begin
      if (pos < BW'(SAMPLE_W)) begin
        sh = smp >> (BW'(SAMPLE_W - 1) - pos);
        r  = sh[0];
      end else begin
        r = 1'b0;
      end
    end else begin
      // I2S delays the MSB by one bck, so slot position 0 is always zero
      if ((pos != '0) && (pos <= BW'(SAMPLE_W))) begin
        sh = smp >> (BW'(SAMPLE_W) - pos);
        r  = sh[0];
      end else begin
        r = 1'b0;
      end
    end
    return r;
  endfunction

  assign in_if.in_ready = in_ready_q;
  assign audio_req      = audio_req_q;
  assign level          = count_q;
  assign underrun       = underrun_q;
  assign bck            = bck_q;
  assign lrck           = lrck_q;
  assign sout           = sout_q;

  assign div_wrap_s  = (div_q == DIV_LAST);
  assign bit_last_s  = (bit_q == BIT_LAST);
  assign empty_s     = (count_q == '0);
  assign push_s      = in_if.in_valid && in_ready_q;

`ifdef I2S_TX_REPEAT_ON_UNDERRUN_EN
  assign fill_word_s = last_q;
`else
  assign fill_word_s = '0;
`endif

  // Next-state logic: transmitter FSM, bck/bit counters, FIFO and flags
  always_comb begin
    state_d       = state_q;
    div_d         = div_q;
    bit_d         = bit_q;
    word_d        = word_q;
    just_d        = just_q;
    frame_start_s = 1'b0;
    entering_s    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        div_d = '0;
        bit_d = '0;
        if (enable) begin
          state_d       = ST_RUN;
          frame_start_s = 1'b1;
          entering_s    = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (div_wrap_s) begin
          div_d = '0;
          if (bit_last_s) begin
            bit_d = '0;
            // enable only matters here, so a frame always completes
            if (enable) begin
              frame_start_s = 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        div_d   = '0;
        bit_d   = '0;
      end
    endcase

    // Pop only when a frame starts; an empty FIFO is never bypassed by a
    // same-cycle push, the frame underruns and the pushed word is stored.
    pop_s = frame_start_s && !empty_s;

    if (frame_start_s) begin
      just_d = justify;
      if (empty_s) begin
        word_d = fill_word_s;
      end else begin
        word_d = mem_q[rd_ptr_q];
      end
    end else begin
      just_d = just_q;
      word_d = word_q;
    end

`ifdef I2S_TX_REPEAT_ON_UNDERRUN_EN
    if (pop_s) begin
      last_d = mem_q[rd_ptr_q];
    end else begin
      last_d = last_q;
    end
`endif

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    count_d    = count_q + {{(LW-1){1'b0}}, push_s} - {{(LW-1){1'b0}}, pop_s};
    in_ready_d = (count_d != DEPTH_L);

    audio_req_d = (pop_s || entering_s) && (count_d < REQ_L);

    if (frame_start_s && empty_s) begin
      underrun_d = 1'b1;
    end else if (underrun_clr) begin
      underrun_d = 1'b0;
    end else begin
      underrun_d = underrun_q;
    end

    // Outputs follow the next counter values so they are true registers;
    // sout/lrck only move when the counters wrap, i.e. at bck falling edges.
    if (state_d == ST_RUN) begin
      bck_d  = (div_d >= DIV_HALF);
      lrck_d = (bit_d >= SLOT_L);
      sout_d = slot_bit(word_d, bit_d, just_d);
    end else begin
      bck_d  = 1'b0;
      lrck_d = 1'b0;
      sout_d = 1'b0;
    end
  end

  // Control, counter, flag and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      div_q       <= '0;
      bit_q       <= '0;
      word_q      <= '0;
      just_q      <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      in_ready_q  <= 1'b1;
      underrun_q  <= 1'b0;
      audio_req_q <= 1'b0;
      bck_q       <= 1'b0;
      lrck_q      <= 1'b0;
      sout_q      <= 1'b0;
`ifdef I2S_TX_REPEAT_ON_UNDERRUN_EN
      last_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      bit_q       <= bit_d;
      word_q      <= word_d;
      just_q      <= just_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      in_ready_q  <= in_ready_d;
      underrun_q  <= underrun_d;
      audio_req_q <= audio_req_d;
      bck_q       <= bck_d;
      lrck_q      <= lrck_d;
      sout_q      <= sout_d;
`ifdef I2S_TX_REPEAT_ON_UNDERRUN_EN
      last_q      <= last_d;
`endif
    end
  end

  // FIFO storage; contents need no reset because the pointers are reset
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= in_if.in_data;
    end
  end

endmodule

// File: doc/i2s_tx_fifo.md
# i2s_tx_fifo

Single-clock, parametrised I2S/left-justified stereo transmitter for the NeXT sound-out path. Accepts packed {left,right} sample words from the bus-side logic into an internal FIFO, generates bck/lrck from the system clock by division, serialises one stereo frame per lrck period, and pulses an audio request toward the NeXT hardware when buffer level runs low. It replaces the two-clock sender: all logic runs on `clk`, so no domain-crossing synchronisers are needed.

## Interface
- `SAMPLE_W`, 16: bits per channel sample.
- `SLOT_W`, 32: bck periods per channel slot; must be ≥ `SAMPLE_W`+1.
- `FIFO_DEPTH`, 8: stereo words buffered; power of two, ≥2.
- `BCK_DIV`, 8: clk cycles per bck period; even, ≥2.
- `REQ_LEVEL`, 4: audio_req threshold; 1..`FIFO_DEPTH`.
- `clk` in 1: system clock; all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `in_valid` in 1: `in_data` valid this cycle.
- `in_ready` out 1: FIFO not full; write occurs when `in_valid && in_ready`.
- `in_data` in 2*`SAMPLE_W`: {left[MSBs], right[LSBs]}.
- `enable` in 1: run serial output.
- `justify` in 1: 0 = I2S (1-bck MSB delay), 1 = left-justified.
- `audio_req` out 1: one-clk request pulse.
- `level` out clog2(`FIFO_DEPTH`+1): FIFO occupancy.
- `underrun` out 1: sticky underrun flag.
- `underrun_clr` in 1: clears `underrun`.
- `bck` out 1: bit clock, 50% duty.
- `lrck` out 1: 0 = left slot, 1 = right slot.
- `sout` out 1: serial data.

## Operation
- Reset: `bck`=0, `lrck`=0, `sout`=0, `audio_req`=0, `in_ready`=1, `level`=0, `underrun`=0; FIFO emptied; divider and bit counter at 0; transmitter idle. Reset mid-frame aborts immediately; no partial frame resumes.
- Counters: divider `div` 0..`BCK_DIV`-1; bit counter `bit` 0..2*`SLOT_W`-1, advances when `div` wraps. `bck` = (`div` ≥ `BCK_DIV`/2). `lrck` = (`bit` ≥ `SLOT_W`).
- States: IDLE (counters held 0, outputs 0) → RUN on `enable`=1. RUN → IDLE when `enable`=0 at a frame boundary (`bit` wraps to 0); the current frame always completes.
- Frame load: at each frame start in RUN (entry from IDLE and every `bit` wrap), pop one word into the shift register. FIFO empty at that instant: load zeros, set `underrun`.
- Bit mapping, slot position p = `bit` mod `SLOT_W`: I2S mode sends sample bit `SAMPLE_W`-p for p in 1..`SAMPLE_W`; left-justified sends bit `SAMPLE_W`-1-p for p in 0..`SAMPLE_W`-1; all other positions 0. Left slot uses the left half, right slot the right half.
- FIFO: `in_ready` = !full, registered. A push while full is ignored even if a pop occurs that cycle. A push into an empty FIFO on a pop cycle is not bypassed: the pop underruns, the word is stored.
- `level` updates the cycle after push/pop; simultaneous push and pop leave it unchanged.
- `audio_req`: one-clk pulse the cycle after a pop leaving `level` < `REQ_LEVEL`, and the cycle after IDLE→RUN if `level` < `REQ_LEVEL`. At most one pulse per frame.
- `underrun_clr` clears the flag; a simultaneous new underrun wins (flag stays 1).

## Timing
- `sout`, `lrck`, `bck` are registers; `sout`/`lrck` change only at `bck` falling edges (`div` wrap) and are stable across the rising edge.
- Frame = 2*`SLOT_W`*`BCK_DIV` clk; defaults 512 clk.
- `enable` rise → first `bck` rise `BCK_DIV`/2+1 clk later; MSB of the popped left sample on `sout` at `bit`=1 (I2S) or `bit`=0 (LJ).
- Push to availability for the next frame load: 1 clk.
- `justify` and `enable` are sampled only at frame boundaries.

## Configuration
- `I2S_TX_REPEAT_ON_UNDERRUN_EN` defined: on underrun the shift register reloads the last transmitted word (zeros if none since reset); `underrun` still set.
- Undefined: underrun frames transmit zeros.

## Test plan
- Reset: assert `reset` during RUN mid-frame → next clk `bck`=`lrck`=`sout`=0, `level`=0, `in_ready`=1, `underrun`=0, `audio_req`=0.
- I2S frame: defaults, push 0xA5A53C3C, raise `enable` → `lrck` low 32 bck then high 32 bck; `sout` = 0, then 0xA5A5 MSB-first, then 15 zeros; right slot 0, then 0x3C3C, then zeros; `audio_req` pulses once (level 0 < 4).
- Left-justified: `justify`=1, same word → 0xA5A5 starts at `bit` 0, 0x3C3C at `bit` 32.
- Underrun: RUN with empty FIFO → frame all zeros, `underrun`=1; pulse `underrun_clr` → 0; with macro defined and prior word 0x12345678 → 0x1234/0x5678 repeated.
- Backpressure: push 9 words with `enable`=0 → `in_ready`=0 after 8, `level`=8, 9th dropped; enable → words emerge in order, `audio_req` first pulses at the pop leaving `level`=3.
- Stop: drop `enable` mid-frame → frame completes, then IDLE with outputs 0 and remaining `level` unchanged.
